// File: rtl/gate_arbiter.sv
// Shares one registered bitwise unit (OR/AND/XOR/NOR) among NREQ requesters; round-robin, or fixed priority with GATE_ARB_FIXED_PRIO_EN.
// Latency: grant one edge after req is sampled, res_valid one edge later; one result per 2 cycles back-to-back.
// Backpressure: requesters hold req and operands until gnt; losers keep waiting, no result-side stall.
module gate_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ*WIDTH-1:0]     op_a,
  input  logic [NREQ*WIDTH-1:0]     op_b,
  input  logic [NREQ*2-1:0]         op_sel,
  output logic [NREQ-1:0]           gnt,
  output logic [WIDTH-1:0]          res,
  output logic                      res_valid,
  output logic [$clog2(NREQ)-1:0]   res_id,
  output logic                      busy
);

  localparam int IDW = $clog2(NREQ);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [NREQ-1:0]    r_gnt;
  logic [NREQ-1:0]    w_gnt_nxt;
  logic [WIDTH-1:0]   r_res;
  logic [WIDTH-1:0]   w_res_nxt;
  logic               r_res_vld;
  logic               w_res_vld_nxt;
  logic [IDW-1:0]     r_res_id;
  logic [IDW-1:0]     w_res_id_nxt;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [1:0]         r_op;
  logic [IDW-1:0]     r_win;
  logic               w_lat;
  logic               w_any;
  logic [IDW-1:0]     w_win;
  logic [WIDTH-1:0]   w_sel_a;
  logic [WIDTH-1:0]   w_sel_b;
  logic [1:0]         w_sel_op;

  function automatic logic [WIDTH-1:0] f_eval(input logic [1:0] op,
                                              input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] v;
    case (op)
      2'b00:   v = a | b;
      2'b01:   v = a & b;
      2'b10:   v = a ^ b;
      default: v = ~(a | b);
    endcase
    return v;
  endfunction

  assign w_any = |req;

`ifdef GATE_ARB_FIXED_PRIO_EN
  // Lowest index wins: scan downward so the last hit is the smallest index.
  always_comb begin
    w_win = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[i]) w_win = IDW'(i);
    end
  end
`else
  localparam logic [IDW:0] NREQ_W = (IDW+1)'(NREQ);
  localparam logic [IDW-1:0] LAST = IDW'(NREQ - 1);

  logic [IDW-1:0] r_ptr;
  logic [IDW:0]   w_idx;
  logic           w_found;

  // Search starts at r_ptr and wraps; the first requester found wins.
  always_comb begin
    w_win   = '0;
    w_found = 1'b0;
    w_idx   = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_idx = {1'b0, r_ptr} + (IDW+1)'(i);
      if (w_idx >= NREQ_W) w_idx = w_idx - NREQ_W;
      if (!w_found && req[w_idx[IDW-1:0]]) begin
        w_win   = w_idx[IDW-1:0];
        w_found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (w_lat) begin
      r_ptr <= (w_win == LAST) ? '0 : w_win + 1'b1;
    end
  end
`endif

  always_comb begin
    w_sel_a  = '0;
    w_sel_b  = '0;
    w_sel_op = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_win == IDW'(i)) begin
        w_sel_a  = op_a[i*WIDTH +: WIDTH];
        w_sel_b  = op_b[i*WIDTH +: WIDTH];
        w_sel_op = op_sel[i*2 +: 2];
      end
    end
  end

  // DONE arbitrates exactly like IDLE so back-to-back grants need no idle cycle.
  always_comb begin
    w_state_nxt   = r_state;
    w_gnt_nxt     = '0;
    w_res_nxt     = r_res;
    w_res_vld_nxt = 1'b0;
    w_res_id_nxt  = r_res_id;
    w_lat         = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (w_any) begin
          w_state_nxt      = S_EXEC;
          w_gnt_nxt[w_win] = 1'b1;
          w_lat            = 1'b1;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_EXEC: begin
        w_res_nxt     = f_eval(r_op, r_a, r_b);
        w_res_id_nxt  = r_win;
        w_res_vld_nxt = 1'b1;
        w_state_nxt   = S_DONE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_gnt     <= '0;
      r_res     <= '0;
      r_res_vld <= 1'b0;
      r_res_id  <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_op      <= '0;
      r_win     <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_gnt     <= w_gnt_nxt;
      r_res     <= w_res_nxt;
      r_res_vld <= w_res_vld_nxt;
      r_res_id  <= w_res_id_nxt;
      if (w_lat) begin
        r_a   <= w_sel_a;
        r_b   <= w_sel_b;
        r_op  <= w_sel_op;
        r_win <= w_win;
      end
    end
  end

  assign gnt       = r_gnt;
  assign res       = r_res;
  assign res_valid = r_res_vld;
  assign res_id    = r_res_id;
  assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_gate_arbiter.sv
// Self-checking bench for gate_arbiter: vector table, directed corner sequences, random traffic vs. reference model.
module tb_gate_arbiter;
  localparam int N  = 4;
  localparam int W  = 4;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req;
  logic [N*W-1:0]  op_a;
  logic [N*W-1:0]  op_b;
  logic [N*2-1:0]  op_sel;
  logic [N-1:0]    gnt;
  logic [W-1:0]    res;
  logic            res_valid;
  logic [IW-1:0]   res_id;
  logic            busy;

  gate_arbiter #(.NREQ(N), .WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .op_a(op_a), .op_b(op_b),
    .op_sel(op_sel), .gnt(gnt), .res(res), .res_valid(res_valid),
    .res_id(res_id), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [1:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] exp;
    int         who;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    req   = '0;
    step;
    step;
    rst_n = 1'b1;
  endtask

  task automatic set_op(input int i, input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    op_a[i*W +: W]   = a;
    op_b[i*W +: W]   = b;
    op_sel[i*2 +: 2] = op;
  endtask

  function automatic logic [W-1:0] ref_eval(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    case (op)
      2'b00:   return a | b;
      2'b01:   return a & b;
      2'b10:   return a ^ b;
      default: return ~(a | b);
    endcase
  endfunction

  function automatic int ref_pick(input logic [N-1:0] r, input int ptr);
`ifdef GATE_ARB_FIXED_PRIO_EN
    for (int i = 0; i < N; i++) if (r[i]) return i;
`else
    for (int i = 0; i < N; i++) if (r[(ptr + i) % N]) return (ptr + i) % N;
`endif
    return -1;
  endfunction

  initial begin
    int             ptr_m;
    int             free_at;
    bit             pend;
    logic [W-1:0]   pend_res;
    int             pend_id;
    bit             v_exp;
    logic [W-1:0]   r_exp;
    int             i_exp;
    logic [N-1:0]   g_exp;
    logic [N-1:0]   req_s;
    logic [N*W-1:0] a_s;
    logic [N*W-1:0] b_s;
    logic [N*2-1:0] s_s;
    int             w;
    int             exp_k;

    tbl[0] = '{2'b00, 4'b1100, 4'b1010, 4'b1110, 0};
    tbl[1] = '{2'b01, 4'b1100, 4'b1010, 4'b1000, 1};
    tbl[2] = '{2'b10, 4'b1100, 4'b1010, 4'b0110, 2};
    tbl[3] = '{2'b11, 4'b1100, 4'b1010, 4'b0001, 3};
    tbl[4] = '{2'b00, 4'b0000, 4'b0000, 4'b0000, 3};
    tbl[5] = '{2'b11, 4'b0000, 4'b0000, 4'b1111, 0};
    tbl[6] = '{2'b10, 4'b1111, 4'b0101, 4'b1010, 1};
    tbl[7] = '{2'b01, 4'b0110, 4'b0011, 4'b0010, 2};
    tbl[8] = '{2'b00, 4'b0001, 4'b0000, 4'b0001, 0};

    rst_n  = 1'b0;
    req    = '0;
    op_a   = '0;
    op_b   = '0;
    op_sel = '0;
    step;
    chk("rst_gnt", gnt, 0);
    chk("rst_res", res, 0);
    chk("rst_vld", res_valid, 0);
    chk("rst_id", res_id, 0);
    chk("rst_busy", busy, 0);
    step;
    rst_n = 1'b1;
    step;

    for (int k = 0; k < 9; k++) begin
      set_op(tbl[k].who, tbl[k].op, tbl[k].a, tbl[k].b);
      req = N'(1) << tbl[k].who;
      step;
      chk("vec_gnt", gnt, N'(1) << tbl[k].who);
      chk("vec_vld_early", res_valid, 0);
      chk("vec_busy", busy, 1);
      req = '0;
      step;
      chk("vec_vld", res_valid, 1);
      chk("vec_res", res, tbl[k].exp);
      chk("vec_id", res_id, tbl[k].who);
      chk("vec_gnt_off", gnt, 0);
      step;
      chk("vec_vld_off", res_valid, 0);
      chk("vec_idle", busy, 0);
      chk("vec_res_hold", res, tbl[k].exp);
    end

    // Contention: all four held, result tags each requester
    do_reset;
    for (int i = 0; i < N; i++) set_op(i, 2'b10, W'(i), '0);
    req = '1;
    for (int k = 0; k < 5; k++) begin
`ifdef GATE_ARB_FIXED_PRIO_EN
      exp_k = 0;
`else
      exp_k = k % N;
`endif
      step;
      chk("cont_gnt", gnt, N'(1) << exp_k);
      chk("cont_vld_low", res_valid, 0);
      step;
      chk("cont_vld", res_valid, 1);
      chk("cont_id", res_id, exp_k);
      chk("cont_res", res, exp_k);
      chk("cont_gnt_low", gnt, 0);
    end
    req = '0;
    step;
    step;

    // Wrap/skip: serve 2 alone (ptr -> 3), then 0 and 2 request together
    do_reset;
    set_op(0, 2'b00, 4'b0011, 4'b0000);
    set_op(2, 2'b00, 4'b0101, 4'b0000);
    req = 4'b0100;
    step;
    chk("wrap_pre_gnt", gnt, 4'b0100);
    req = '0;
    step;
    step;
    req = 4'b0101;
    step;
    chk("wrap_gnt0", gnt, 4'b0001);
    req = 4'b0100;
    step;
    chk("wrap_id0", res_id, 0);
    chk("wrap_res0", res, 4'b0011);
    step;
    chk("wrap_gnt2", gnt, 4'b0100);
    req = '0;
    step;
    chk("wrap_id2", res_id, 2);
    chk("wrap_res2", res, 4'b0101);
    step;

    // Operands changed right after grant must not affect res
    set_op(1, 2'b01, 4'b1100, 4'b1010);
    req = 4'b0010;
    step;
    chk("opchg_gnt", gnt, 4'b0010);
    set_op(1, 2'b00, 4'b0011, 4'b0101);
    req = '0;
    step;
    chk("opchg_res", res, 4'b1000);
    set_op(1, 2'b11, 4'b0000, 4'b0000);
    step;
    chk("opchg_res_hold", res, 4'b1000);

    // Asynchronous reset in the middle of EXEC
    set_op(3, 2'b00, 4'b1111, 4'b0000);
    req = 4'b1000;
    step;
    chk("mid_gnt", gnt, 4'b1000);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_gnt", gnt, 0);
    chk("mid_rst_vld", res_valid, 0);
    chk("mid_rst_res", res, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_id", res_id, 0);
    req = '0;
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step;
      chk("mid_no_result", res_valid, 0);
    end

    // Random traffic against the reference model
    ptr_m   = 0;
    free_at = 0;
    pend    = 1'b0;
    pend_res = '0;
    pend_id = 0;
    for (int i = 0; i < N; i++) set_op(i, 2'($urandom_range(3)), W'($urandom), W'($urandom));
    for (int c = 0; c < 400; c++) begin
      req_s = req;
      a_s   = op_a;
      b_s   = op_b;
      s_s   = op_sel;
      step;
      v_exp = pend;
      r_exp = pend_res;
      i_exp = pend_id;
      pend  = 1'b0;
      g_exp = '0;
      if (req_s != '0 && c >= free_at) begin
        w        = ref_pick(req_s, ptr_m);
        g_exp[w] = 1'b1;
        ptr_m    = (w + 1) % N;
        free_at  = c + 2;
        pend     = 1'b1;
        pend_id  = w;
        pend_res = ref_eval(s_s[w*2 +: 2], a_s[w*W +: W], b_s[w*W +: W]);
      end
      chk("rnd_gnt", gnt, g_exp);
      chk("rnd_vld", res_valid, v_exp);
      chk("rnd_busy", busy, (g_exp != '0) || v_exp);
      if (v_exp) begin
        chk("rnd_res", res, r_exp);
        chk("rnd_id", res_id, i_exp);
      end
      for (int i = 0; i < N; i++) begin
        if (g_exp[i]) begin
          req[i] = 1'b0;
          set_op(i, 2'($urandom_range(3)), W'($urandom), W'($urandom));
        end else if (req[i]) begin
          if ($urandom_range(15) == 0) req[i] = 1'b0;
        end else if ($urandom_range(3) == 0) begin
          set_op(i, 2'($urandom_range(3)), W'($urandom), W'($urandom));
          req[i] = 1'b1;
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
